// File: rtl/timer_pkg.sv
// Shared types and constants for the two-mode timer core.
package timer_pkg;

    localparam int unsigned BIN_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [BIN_W-1:0] MAX_SEC = 8'd59;
    localparam logic [BIN_W-1:0] MAX_MIN = 8'd99;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    // Saturate a preset field to its legal maximum.
    function automatic logic [BIN_W-1:0] clamp(input logic [BIN_W-1:0] v,
                                               input logic [BIN_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// One-second prescaler: counts 0..TICKS_PER_SEC-1 while enabled, tick on wrap.
// last_c flags the terminal count so the sequencer can let a pending tick
// complete in the cycle a pause is requested.
module sec_prescaler #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic last_c,
    output logic tick_c
);

    localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt;

    assign last_c = (cnt == LAST);
    assign tick_c = enable && last_c;

    // Prescaler count; clear wins over enable.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= last_c ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/timer_sequencer.sv
// Timer control core: start/pause/clear/expiry FSM with minute/second counters.
// Optional lap-freeze of the displayed value when LAP_EN is defined.
module timer_sequencer
    import timer_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             StartStop,
    input  logic             Clear,
    input  logic             ModeIn,
    input  logic [BIN_W-1:0] PresetMin,
    input  logic [BIN_W-1:0] PresetSec,
    input  logic             Lap,
    output logic [BIN_W-1:0] MSBBinary,
    output logic [BIN_W-1:0] LSBBinary,
    output logic             ModeSel,
    output logic             Running,
    output logic             Expired
);

    state_e           state, nxt_state;
    logic [BIN_W-1:0] sec, nxt_sec, min, nxt_min;
    logic [BIN_W-1:0] lim_sec, nxt_lim_sec, lim_min, nxt_lim_min;
    logic             mode, nxt_mode;
    logic [BIN_W-1:0] nxt_msb, nxt_lsb;
    logic [BIN_W-1:0] inc_sec, inc_min, preset_sec_c, preset_min_c;
    logic             pre_en, pre_clr, last_c, tick_c;

    assign preset_sec_c = clamp(PresetSec, MAX_SEC);
    assign preset_min_c = clamp(PresetMin, MAX_MIN);
    assign inc_sec      = (sec == MAX_SEC) ? '0 : sec + 8'd1;
    assign inc_min      = (sec == MAX_SEC) ? min + 8'd1 : min;

    // A pause freezes the prescaler in its own cycle unless a tick is due then.
    assign pre_en = (state == RUN) && (!StartStop || last_c);

    sec_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .clk    (Clock),
        .rst    (Reset),
        .enable (pre_en),
        .clear  (pre_clr),
        .last_c (last_c),
        .tick_c (tick_c)
    );

    // Next-state, counter and preset-latch logic; Clear overrides everything.
    always_comb begin
        nxt_state   = state;
        nxt_sec     = sec;
        nxt_min     = min;
        nxt_mode    = mode;
        nxt_lim_sec = lim_sec;
        nxt_lim_min = lim_min;
        pre_clr     = 1'b0;
        case (state)
            IDLE: begin
                nxt_mode = ModeIn;
                nxt_sec  = '0;
                nxt_min  = '0;
                if (StartStop) begin
                    pre_clr = 1'b1;
                    if (ModeIn == MODE_DOWN) begin
                        nxt_lim_sec = preset_sec_c;
                        nxt_lim_min = preset_min_c;
                        nxt_state   = ((preset_sec_c == '0) && (preset_min_c == '0)) ? DONE : RUN;
                    end else begin
                        nxt_lim_sec = MAX_SEC;
                        nxt_lim_min = MAX_MIN;
                        nxt_state   = RUN;
                    end
                end
            end
            RUN: begin
                if (tick_c) begin
                    nxt_sec = inc_sec;
                    nxt_min = inc_min;
                end
                if (tick_c && (inc_sec == lim_sec) && (inc_min == lim_min)) begin
                    nxt_state = DONE;
                end else if (StartStop) begin
                    nxt_state = PAUSE;
                end
            end
            PAUSE: begin
                if (StartStop) begin
                    nxt_state = RUN;
                end
            end
            DONE: begin
                nxt_state = DONE;
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
        if (Clear) begin
            nxt_state = IDLE;
            nxt_sec   = '0;
            nxt_min   = '0;
            pre_clr   = 1'b1;
        end
    end

`ifdef LAP_EN
    logic freeze, nxt_freeze;

    // Display select: hold the captured value while frozen, else show live count.
    always_comb begin
        nxt_freeze = freeze;
        if (Lap && ((state == RUN) || (state == PAUSE))) begin
            nxt_freeze = !freeze;
        end
        if ((nxt_state != RUN) && (nxt_state != PAUSE)) begin
            nxt_freeze = 1'b0;
        end
        nxt_msb = nxt_min;
        nxt_lsb = nxt_sec;
        if (freeze && nxt_freeze) begin
            nxt_msb = MSBBinary;
            nxt_lsb = LSBBinary;
        end
    end

    // Lap freeze flag.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            freeze <= 1'b0;
        end else begin
            freeze <= nxt_freeze;
        end
    end
`else
    logic unused_lap;
    assign unused_lap = Lap;

    // Display always shows the live count.
    always_comb begin
        nxt_msb = nxt_min;
        nxt_lsb = nxt_sec;
    end
`endif

    // State, counters, latched mode/limit and registered outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            sec       <= '0;
            min       <= '0;
            lim_sec   <= '0;
            lim_min   <= '0;
            mode      <= MODE_UP;
            MSBBinary <= '0;
            LSBBinary <= '0;
            ModeSel   <= 1'b0;
            Running   <= 1'b0;
            Expired   <= 1'b0;
        end else begin
            state     <= nxt_state;
            sec       <= nxt_sec;
            min       <= nxt_min;
            lim_sec   <= nxt_lim_sec;
            lim_min   <= nxt_lim_min;
            mode      <= nxt_mode;
            MSBBinary <= nxt_msb;
            LSBBinary <= nxt_lsb;
            ModeSel   <= nxt_mode;
            Running   <= (nxt_state == RUN);
            Expired   <= (nxt_state == DONE);
        end
    end

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer with TICKS_PER_SEC=4.
// Honours LAP_EN the same way as the design.
module tb_timer_sequencer;

    logic       Clock;
    logic       Reset;
    logic       StartStop;
    logic       Clear;
    logic       ModeIn;
    logic [7:0] PresetMin;
    logic [7:0] PresetSec;
    logic       Lap;
    logic [7:0] MSBBinary;
    logic [7:0] LSBBinary;
    logic       ModeSel;
    logic       Running;
    logic       Expired;

    int errors = 0;
    int checks = 0;

    timer_sequencer #(
        .TICKS_PER_SEC(4)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .StartStop (StartStop),
        .Clear     (Clear),
        .ModeIn    (ModeIn),
        .PresetMin (PresetMin),
        .PresetSec (PresetSec),
        .Lap       (Lap),
        .MSBBinary (MSBBinary),
        .LSBBinary (LSBBinary),
        .ModeSel   (ModeSel),
        .Running   (Running),
        .Expired   (Expired)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Each negedge wait lets exactly one rising edge pass.
    task automatic cycles(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic pulse_ss();
        StartStop = 1'b1;
        @(negedge Clock);
        StartStop = 1'b0;
    endtask

    task automatic pulse_clear();
        Clear = 1'b1;
        @(negedge Clock);
        Clear = 1'b0;
    endtask

    task automatic pulse_lap();
        Lap = 1'b1;
        @(negedge Clock);
        Lap = 1'b0;
    endtask

    task automatic test_reset();
        ModeIn = 1'b1;
        Reset  = 1'b1;
        cycles(2);
        checks++; if (MSBBinary !== 8'd0) begin errors++; $display("FAIL reset_msb: got %0d want 0", MSBBinary); end
        checks++; if (LSBBinary !== 8'd0) begin errors++; $display("FAIL reset_lsb: got %0d want 0", LSBBinary); end
        checks++; if (ModeSel !== 1'b0) begin errors++; $display("FAIL reset_modesel: got %b want 0", ModeSel); end
        checks++; if (Running !== 1'b0 || Expired !== 1'b0) begin errors++; $display("FAIL reset_flags: got run=%b exp=%b want 0 0", Running, Expired); end
        Reset = 1'b0;
        cycles(1);
    endtask

    task automatic test_count_up();
        ModeIn = 1'b0;
        cycles(1);
        pulse_ss();
        checks++; if (Running !== 1'b1 || LSBBinary !== 8'd0) begin errors++; $display("FAIL start_edge: got run=%b lsb=%0d want 1 0", Running, LSBBinary); end
        cycles(3);
        checks++; if (LSBBinary !== 8'd0) begin errors++; $display("FAIL pre_first_tick: got %0d want 0", LSBBinary); end
        cycles(1);
        checks++; if (LSBBinary !== 8'd1) begin errors++; $display("FAIL first_tick: got %0d want 1", LSBBinary); end
        cycles(12);
        checks++; if (LSBBinary !== 8'd4 || Running !== 1'b1 || ModeSel !== 1'b0) begin errors++; $display("FAIL sw_16cyc: got lsb=%0d run=%b mode=%b want 4 1 0", LSBBinary, Running, ModeSel); end
    endtask

    task automatic test_minute_wrap();
        cycles(220);
        checks++; if (MSBBinary !== 8'd0 || LSBBinary !== 8'd59) begin errors++; $display("FAIL at_0059: got %0d:%0d want 0:59", MSBBinary, LSBBinary); end
        cycles(3);
        checks++; if (LSBBinary !== 8'd59) begin errors++; $display("FAIL hold_0059: got %0d want 59", LSBBinary); end
        cycles(1);
        checks++; if (MSBBinary !== 8'd1 || LSBBinary !== 8'd0) begin errors++; $display("FAIL wrap_0100: got %0d:%0d want 1:0", MSBBinary, LSBBinary); end
    endtask

    task automatic test_pause();
        cycles(2);
        pulse_ss();
        checks++; if (Running !== 1'b0 || MSBBinary !== 8'd1 || LSBBinary !== 8'd0) begin errors++; $display("FAIL pause_enter: got run=%b %0d:%0d want 0 1:0", Running, MSBBinary, LSBBinary); end
        cycles(10);
        checks++; if (Running !== 1'b0 || LSBBinary !== 8'd0 || Expired !== 1'b0) begin errors++; $display("FAIL pause_hold: got run=%b lsb=%0d exp=%b want 0 0 0", Running, LSBBinary, Expired); end
        pulse_ss();
        checks++; if (Running !== 1'b1 || LSBBinary !== 8'd0) begin errors++; $display("FAIL resume_edge: got run=%b lsb=%0d want 1 0", Running, LSBBinary); end
        cycles(1);
        checks++; if (LSBBinary !== 8'd0) begin errors++; $display("FAIL resume_plus1: got %0d want 0", LSBBinary); end
        cycles(1);
        checks++; if (LSBBinary !== 8'd1 || MSBBinary !== 8'd1) begin errors++; $display("FAIL resume_tick: got %0d:%0d want 1:1", MSBBinary, LSBBinary); end
    endtask

    task automatic test_clear_beats_start();
        Clear     = 1'b1;
        StartStop = 1'b1;
        @(negedge Clock);
        Clear     = 1'b0;
        StartStop = 1'b0;
        checks++; if (MSBBinary !== 8'd0 || LSBBinary !== 8'd0 || Running !== 1'b0 || Expired !== 1'b0) begin errors++; $display("FAIL clear_ss: got %0d:%0d run=%b exp=%b want 0:0 0 0", MSBBinary, LSBBinary, Running, Expired); end
        cycles(8);
        checks++; if (LSBBinary !== 8'd0 || Running !== 1'b0) begin errors++; $display("FAIL clear_stays_idle: got lsb=%0d run=%b want 0 0", LSBBinary, Running); end
    endtask

    task automatic test_countdown();
        ModeIn    = 1'b1;
        PresetMin = 8'd0;
        PresetSec = 8'd3;
        cycles(1);
        checks++; if (ModeSel !== 1'b1) begin errors++; $display("FAIL idle_modesel: got %b want 1", ModeSel); end
        pulse_ss();
        cycles(11);
        checks++; if (LSBBinary !== 8'd2 || Expired !== 1'b0) begin errors++; $display("FAIL cd_pre_done: got lsb=%0d exp=%b want 2 0", LSBBinary, Expired); end
        cycles(1);
        checks++; if (LSBBinary !== 8'd3 || Expired !== 1'b1 || Running !== 1'b0 || ModeSel !== 1'b1) begin errors++; $display("FAIL cd_done: got lsb=%0d exp=%b run=%b mode=%b want 3 1 0 1", LSBBinary, Expired, Running, ModeSel); end
        pulse_ss();
        cycles(4);
        checks++; if (LSBBinary !== 8'd3 || Expired !== 1'b1 || Running !== 1'b0) begin errors++; $display("FAIL done_ignores_ss: got lsb=%0d exp=%b run=%b want 3 1 0", LSBBinary, Expired, Running); end
        pulse_clear();
        checks++; if (LSBBinary !== 8'd0 || Expired !== 1'b0 || ModeSel !== 1'b1) begin errors++; $display("FAIL done_clear: got lsb=%0d exp=%b mode=%b want 0 0 1", LSBBinary, Expired, ModeSel); end
    endtask

    task automatic test_zero_preset();
        ModeIn    = 1'b1;
        PresetMin = 8'd0;
        PresetSec = 8'd0;
        pulse_ss();
        checks++; if (Expired !== 1'b1 || Running !== 1'b0 || LSBBinary !== 8'd0) begin errors++; $display("FAIL zero_preset_done: got exp=%b run=%b lsb=%0d want 1 0 0", Expired, Running, LSBBinary); end
        pulse_clear();
        ModeIn = 1'b0;
        pulse_ss();
        checks++; if (Expired !== 1'b0 || Running !== 1'b1) begin errors++; $display("FAIL zero_preset_sw: got exp=%b run=%b want 0 1", Expired, Running); end
        pulse_clear();
    endtask

    task automatic test_clamp();
        ModeIn    = 1'b1;
        PresetMin = 8'd0;
        PresetSec = 8'd75;
        pulse_ss();
        cycles(235);
        checks++; if (LSBBinary !== 8'd58 || Expired !== 1'b0) begin errors++; $display("FAIL sec_clamp_pre: got lsb=%0d exp=%b want 58 0", LSBBinary, Expired); end
        cycles(1);
        checks++; if (LSBBinary !== 8'd59 || Expired !== 1'b1) begin errors++; $display("FAIL sec_clamp_done: got lsb=%0d exp=%b want 59 1", LSBBinary, Expired); end
        pulse_clear();
        PresetMin = 8'd120;
        PresetSec = 8'd75;
        pulse_ss();
        PresetMin = 8'd0;
        PresetSec = 8'd1;
        cycles(23995);
        checks++; if (MSBBinary !== 8'd99 || LSBBinary !== 8'd58 || Expired !== 1'b0) begin errors++; $display("FAIL full_clamp_pre: got %0d:%0d exp=%b want 99:58 0", MSBBinary, LSBBinary, Expired); end
        cycles(1);
        checks++; if (MSBBinary !== 8'd99 || LSBBinary !== 8'd59 || Expired !== 1'b1 || Running !== 1'b0) begin errors++; $display("FAIL full_clamp_done: got %0d:%0d exp=%b run=%b want 99:59 1 0", MSBBinary, LSBBinary, Expired, Running); end
        pulse_clear();
    endtask

    task automatic test_reset_mid_run();
        ModeIn    = 1'b1;
        PresetMin = 8'd0;
        PresetSec = 8'd10;
        pulse_ss();
        cycles(6);
        checks++; if (LSBBinary !== 8'd1 || Running !== 1'b1) begin errors++; $display("FAIL pre_reset_run: got lsb=%0d run=%b want 1 1", LSBBinary, Running); end
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        checks++; if (ModeSel !== 1'b0 || LSBBinary !== 8'd0 || Running !== 1'b0 || Expired !== 1'b0) begin errors++; $display("FAIL reset_mid_run: got mode=%b lsb=%0d run=%b exp=%b want 0 0 0 0", ModeSel, LSBBinary, Running, Expired); end
        cycles(1);
        checks++; if (ModeSel !== 1'b1) begin errors++; $display("FAIL post_reset_follow: got %b want 1", ModeSel); end
    endtask

    task automatic test_lap();
        ModeIn = 1'b0;
        cycles(1);
        pulse_ss();
        cycles(20);
        checks++; if (LSBBinary !== 8'd5) begin errors++; $display("FAIL lap_at_0005: got %0d want 5", LSBBinary); end
        pulse_lap();
        cycles(8);
`ifdef LAP_EN
        checks++; if (MSBBinary !== 8'd0 || LSBBinary !== 8'd5) begin errors++; $display("FAIL lap_frozen: got %0d:%0d want 0:5", MSBBinary, LSBBinary); end
`else
        checks++; if (MSBBinary !== 8'd0 || LSBBinary !== 8'd7) begin errors++; $display("FAIL lap_ignored: got %0d:%0d want 0:7", MSBBinary, LSBBinary); end
`endif
        pulse_lap();
        checks++; if (LSBBinary !== 8'd7) begin errors++; $display("FAIL lap_release: got %0d want 7", LSBBinary); end
        pulse_lap();
        pulse_clear();
        checks++; if (LSBBinary !== 8'd0 || Running !== 1'b0) begin errors++; $display("FAIL lap_clear: got lsb=%0d run=%b want 0 0", LSBBinary, Running); end
        pulse_ss();
        cycles(4);
        checks++; if (LSBBinary !== 8'd1) begin errors++; $display("FAIL lap_dropped: got %0d want 1", LSBBinary); end
        pulse_clear();
    endtask

    initial begin
        Reset     = 1'b1;
        StartStop = 1'b0;
        Clear     = 1'b0;
        ModeIn    = 1'b0;
        PresetMin = 8'd0;
        PresetSec = 8'd0;
        Lap       = 1'b0;
        @(negedge Clock);
        test_reset();
        test_count_up();
        test_minute_wrap();
        test_pause();
        test_clear_beats_start();
        test_countdown();
        test_zero_preset();
        test_clamp();
        test_reset_mid_run();
        test_lap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_sequencer.md
# timer_sequencer

Control core of the two-mode timer. Generates the minute and second binary values and the mode select that drive the seven-segment encoding path. Sequences start, pause, clear and expiry from single-cycle button pulses. Operates in two modes: stopwatch (count up) and countdown (elapsed count against a preset, shown reversed by the encoder path).

## Interface
Parameters:
- TICKS_PER_SEC, 50_000_000, clock cycles per one-second step (minimum 2).

Ports:
- Clock  input  1  system clock; the only clock.
- Reset  input  1  synchronous, active-high reset.
- StartStop  input  1  single-cycle pulse, debounced upstream; start/pause/resume toggle.
- Clear  input  1  single-cycle pulse; return to IDLE with count 00:00.
- ModeIn  input  1  0 = stopwatch, 1 = countdown; sampled only in IDLE.
- PresetMin  input  8  countdown limit in minutes; sampled on start from IDLE.
- PresetSec  input  8  countdown limit in seconds; sampled on start from IDLE.
- Lap  input  1  single-cycle pulse; toggles display freeze (LAP_EN only).
- MSBBinary  output  8  minutes, 0..99, to encoder MSB input.
- LSBBinary  output  8  seconds, 0..59, to encoder LSB input.
- ModeSel  output  1  registered latched mode, to encoder reversal control.
- Running  output  1  high in RUN.
- Expired  output  1  high in DONE.

## Operation
- FSM states: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - Count held at 00:00.
  - ModeSel follows ModeIn, registered.
  - StartStop latches mode and preset, clears the prescaler, then goes to RUN.
  - In countdown mode with a clamped preset of 00:00, StartStop goes to DONE instead.
- RUN:
  - The prescaler counts 0..TICKS_PER_SEC-1. Its wrap is a tick.
  - On a tick, seconds increment. Seconds 59 wraps to 0 and increments minutes.
  - StartStop goes to PAUSE.
  - Go to DONE when the post-increment count equals the limit. The limit is 99:59 in stopwatch mode and the latched preset in countdown mode.
- PAUSE: count and prescaler frozen. StartStop returns to RUN and resumes the prescaler from its held value.
- DONE: count held at its final value. StartStop is ignored. Only Clear or Reset exits.
- Clear in any state:
  - Go to IDLE and zero the count and prescaler.
  - Clear beats a simultaneous StartStop and a simultaneous tick.
- Preset clamp at latch time: PresetSec above 59 becomes 59; PresetMin above 99 becomes 99.
- Counting is always elapsed/upward in both modes. ModeSel=1 makes the encoder path display the reversed value.
- Arithmetic: seconds and minutes are separate 8-bit registers, never combined. The prescaler is sized $clog2(TICKS_PER_SEC).
- StartStop arriving in the same cycle as a tick in RUN: the tick is applied, then the FSM moves to PAUSE.

## Timing
- All outputs are registered.
- Reset values: MSBBinary=0, LSBBinary=0, ModeSel=0, Running=0, Expired=0, state IDLE, prescaler 0.
- From StartStop in IDLE:
  - Running rises on the next edge.
  - The first tick comes TICKS_PER_SEC cycles after entering RUN.
  - LSBBinary updates on the edge following the tick cycle.
- Expired rises on the same edge on which the final count value appears.
- Clear takes effect on the next edge: outputs are 0 and Expired/Running are low.
- Reset mid-RUN behaves identically to Clear and also forces ModeSel=0.

## Configuration
- LAP_EN defined:
  - Lap toggles a freeze flag. While frozen, MSBBinary/LSBBinary hold the value captured at the Lap edge, and the internal count continues.
  - Lap is ignored outside RUN/PAUSE.
  - Clear, Reset, or entering DONE drops the freeze. On entering DONE the outputs show the final count.
- LAP_EN undefined: the Lap port exists but is ignored, and the outputs always show the live count.

## Structure
- Shared package timer_pkg holds:
  - state enum (IDLE, RUN, PAUSE, DONE);
  - constants MAX_SEC=59 and MAX_MIN=99;
  - MODE_UP=0 and MODE_DOWN=1.
- One sub-module, sec_prescaler:
  - inputs: enable, clear;
  - output: single-cycle tick;
  - parameter: TICKS_PER_SEC.
- FSM and minute/second counters live in timer_sequencer.

## Test plan
All scenarios use TICKS_PER_SEC=4.
- Reset, then ModeIn=0 and StartStop, wait 16 cycles -> LSBBinary=4, Running=1, ModeSel=0.
- Run to 00:59, one more tick -> MSBBinary=1, LSBBinary=0 on the same edge.
- ModeIn=1, preset 00:03, StartStop -> ModeSel=1; after 12 cycles count is 00:03, Expired=1, Running=0; a further StartStop leaves it unchanged.
- StartStop at prescaler=2, hold 10 cycles, StartStop again -> the next tick arrives 2 cycles after resume; count is unchanged during PAUSE.
- Clear and StartStop in the same cycle during RUN -> IDLE, outputs 0. Preset 120:75 -> latched as 99:59. Preset 00:00 in countdown -> DONE on the next edge.
- LAP_EN: Lap at 00:05, run 8 cycles -> outputs still 00:05; Lap again -> 00:07.
